lpf_impulse_sequencer: RTL and testbench
========================================

// Module: lpf_impulse_sequencer
// PURPOSE
//  Sequences in-system impulse-response checks of the 8-lane x 12-bit low-pass filter (LPF).
//  Normally passes live ADC beats to the LPF input. On command it flushes the LPF with zeros,
//  injects a single-beat impulse into one lane, two adjacent lanes or all lanes, then captures
//  a fixed window of LPF output beats into an internal buffer for readback.
//  Sits between the ADC stream and the LPF; the LPF output continues downstream untouched.
// PARAMETERS
//  NSAMP          8    samples per beat (lanes)
//  NBITS          12   bits per sample, two's complement
//  FLUSH_CYCLES   64   zero beats driven before injection (must be >= LPF latency)
//  CAPTURE_DEPTH  256  captured output beats; power of 2, 2..1024
// PORTS
//  aclk        in   1              clock
//  aresetn     in   1              asynchronous reset, active low
//  adc_tdata   in   NSAMP*NBITS    live ADC beat; lane j = [NBITS*j +: NBITS]
//  lpf_in_o    out  NSAMP*NBITS    LPF input beat, registered
//  lpf_out_i   in   NSAMP*NBITS    LPF output beat
//  start_i     in   1              single-cycle pulse: begin a sequence
//  abort_i     in   1              single-cycle pulse: cancel the sequence
//  mode_i      in   2              0 = single lane, 1 = pair (lane, lane+1), 2 = all lanes, 3 = reserved
//  lane_i      in   3              target lane
//  amp_i       in   NBITS          impulse amplitude, signed
//  busy_o      out  1              high while not IDLE/DONE
//  done_o      out  1              sticky: capture complete
//  err_o       out  1              single-cycle pulse: start rejected
//  rd_addr_i   in   log2(DEPTH)    readback beat index
//  rd_data_o   out  NSAMP*NBITS    captured beat; valid 1 cycle after rd_addr_i
// BEHAVIOUR
//  Reset values: lpf_in_o=0, busy_o=0, done_o=0, err_o=0, rd_data_o=0; state IDLE.
//  FSM: IDLE -> FLUSH -> INJECT -> CAPTURE -> DONE; DONE -> FLUSH on a valid start.
//  IDLE/DONE: lpf_in_o <= adc_tdata every cycle (1-cycle pass-through latency).
//  start_i in IDLE/DONE with a valid config: mode, lane and amp are latched; done_o clears; next state FLUSH.
//  Invalid config -> err_o pulses next cycle, state and done_o unchanged:
//    mode_i=3, or mode_i=1 with lane_i=7.
//  start_i in FLUSH/INJECT/CAPTURE is ignored (no err_o).
//  FLUSH: lpf_in_o <= 0 for exactly FLUSH_CYCLES cycles; adc_tdata is ignored.
//  INJECT: one cycle; lpf_in_o <= amp in the selected lane(s), 0 elsewhere.
//  CAPTURE: lpf_in_o <= 0.
//    Beat k (k = 0..DEPTH-1) stores lpf_out_i sampled k cycles after the cycle the impulse is on lpf_in_o.
//    Addr counter wraps to 0 only via the next sequence, never within a capture.
//  After the DEPTH-th write: state DONE, done_o=1; pass-through resumes next cycle.
//  abort_i in FLUSH/INJECT/CAPTURE: next state IDLE, done_o=0, pass-through resumes.
//    The buffer keeps any partial data.
//  abort_i and start_i in the same cycle: abort wins.
//  abort_i in IDLE/DONE: no effect.
//  Readback is allowed in any state. Reading while CAPTURE writes the same address returns old data.
//  Reset mid-sequence: immediate return to IDLE with reset values; buffer contents undefined.
// STRUCTURE
//  Package lpf_seq_pkg:
//    state enum {IDLE, FLUSH, INJECT, CAPTURE, DONE}
//    mode constants MODE_SINGLE=0, MODE_PAIR=1, MODE_ALL=2
//    function lane_mask(mode, lane) -> [NSAMP-1:0]
//  Sub-module lpf_seq_capture_ram: simple dual-port RAM, DEPTH x NSAMP*NBITS, 1-cycle read, no reset.
// TESTING  (bench drives the real LPF; FLUSH_CYCLES=64, DEPTH=256)
//  1. Idle, adc_tdata ramps -> lpf_in_o equals adc_tdata delayed 1 cycle; busy_o=0.
//  2. start mode0 lane3 amp=1000 -> 64 zero beats, one beat with lane3=1000, others 0.
//       Then done_o rises 256 cycles after INJECT.
//       Readback matches the LPF model's impulse response for lane 3.
//  3. Repeat 2 with amp=-1000 (12'hC18) -> captured data is the exact two's-complement negation of run 2.
//  4. mode1 lane6 -> lanes 6,7 = amp.
//       mode1 lane7 -> err_o pulse, busy_o stays 0, done_o keeps its prior value.
//  5. mode2 amp=1000 -> all 8 lanes = 1000 for one beat.
//       Capture equals the sum of the 8 single-lane captures, within LPF rounding.
//  6. abort_i at CAPTURE beat 100 -> busy_o=0 next cycle, done_o=0, pass-through resumes.
//       start_i during FLUSH ignored.
//       aresetn low mid-FLUSH -> all outputs at reset values.

Source files
------------

// File: rtl/lpf_seq_pkg.sv
// Shared types, constants and helpers for the LPF impulse-response sequencer.
package lpf_seq_pkg;

  localparam int unsigned NSAMP  = 8;
  localparam int unsigned NBITS  = 12;
  localparam int unsigned BEAT_W = NSAMP * NBITS;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_PAIR   = 2'd1;
  localparam logic [1:0] MODE_ALL    = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    INJECT,
    CAPTURE,
    DONE
  } state_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [2:0]       lane;
    logic [NBITS-1:0] amp;
  } cfg_t;

  // Lanes that receive the impulse; reserved mode selects none.
  function automatic logic [NSAMP-1:0] lane_mask(input logic [1:0] mode, input logic [2:0] lane);
    logic [NSAMP-1:0] m;
    m = '0;
    case (mode)
      MODE_SINGLE: m = NSAMP'(1) << lane;
      MODE_PAIR:   m = NSAMP'(3) << lane;
      MODE_ALL:    m = '1;
      default:     m = '0;
    endcase
    return m;
  endfunction

  function automatic logic cfg_valid(input logic [1:0] mode, input logic [2:0] lane);
    return !((mode == 2'd3) || ((mode == MODE_PAIR) && (lane == 3'd7)));
  endfunction

  function automatic logic [BEAT_W-1:0] impulse_beat(input logic [NSAMP-1:0] mask,
                                                     input logic [NBITS-1:0] amp);
    logic [BEAT_W-1:0] b;
    b = '0;
    for (int j = 0; j < NSAMP; j++) begin
      if (mask[j]) b[NBITS*j +: NBITS] = amp;
    end
    return b;
  endfunction

endpackage

// File: rtl/lpf_seq_capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
module lpf_seq_capture_ram #(
  parameter  int unsigned DEPTH  = 256,
  parameter  int unsigned WIDTH  = 96,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Storage is never cleared; only the read register returns to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/lpf_impulse_sequencer.sv
// Muxes live ADC beats or a flush/impulse pattern into the LPF and captures
// the resulting LPF output window for readback.
module lpf_impulse_sequencer
  import lpf_seq_pkg::*;
#(
  parameter  int unsigned FLUSH_CYCLES  = 64,
  parameter  int unsigned CAPTURE_DEPTH = 256,
  localparam int unsigned ADDR_W        = $clog2(CAPTURE_DEPTH)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [BEAT_W-1:0] adc_tdata,
  output logic [BEAT_W-1:0] lpf_in_o,
  input  logic [BEAT_W-1:0] lpf_out_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [1:0]        mode_i,
  input  logic [2:0]        lane_i,
  input  logic [NBITS-1:0]  amp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [BEAT_W-1:0] rd_data_o
);

  localparam int unsigned CNT_MAX = (FLUSH_CYCLES > CAPTURE_DEPTH) ? FLUSH_CYCLES : CAPTURE_DEPTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cfg_t              cfg_q, cfg_d;
  logic [BEAT_W-1:0] lpf_in_d;
  logic              busy_d, done_d, err_d;
  logic              wr_en_c;
  logic              start_ok_c;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cfg_q    <= '0;
      lpf_in_o <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cfg_q    <= cfg_d;
      lpf_in_o <= lpf_in_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
      err_o    <= err_d;
    end
  end

  // Abort takes priority over a coincident start.
  assign start_ok_c = start_i && !abort_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cfg_d    = cfg_q;
    lpf_in_d = '0;
    done_d   = done_o;
    err_d    = 1'b0;
    wr_en_c  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        lpf_in_d = adc_tdata;
        if (start_ok_c) begin
          if (cfg_valid(mode_i, lane_i)) begin
            cfg_d   = '{mode: mode_i, lane: lane_i, amp: amp_i};
            done_d  = 1'b0;
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = INJECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      INJECT: begin
        lpf_in_d = impulse_beat(lane_mask(cfg_q.mode, cfg_q.lane), cfg_q.amp);
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        wr_en_c = 1'b1;
        if (cnt_q == CNT_W'(CAPTURE_DEPTH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Partial capture data stays in the buffer after an abort.
    if (abort_i && (state_q == FLUSH || state_q == INJECT || state_q == CAPTURE)) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      lpf_in_d = '0;
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  lpf_seq_capture_ram #(
    .DEPTH (CAPTURE_DEPTH),
    .WIDTH (BEAT_W)
  ) u_ram (
    .clk   (aclk),
    .rst_n (aresetn),
    .we    (wr_en_c),
    .waddr (cnt_q[ADDR_W-1:0]),
    .wdata (lpf_out_i),
    .raddr (rd_addr_i),
    .rdata (rd_data_o)
  );

endmodule

// File: tb/tb_lpf_impulse_sequencer.sv
// Directed bench for the impulse sequencer with a small 3-tap [1 2 1]/4 per-lane LPF in the loop.
module tb_lpf_impulse_sequencer;
  import lpf_seq_pkg::*;

  localparam int unsigned DEPTH = 256;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [BEAT_W-1:0] adc_tdata;
  logic [BEAT_W-1:0] lpf_in_o;
  logic [BEAT_W-1:0] lpf_out_i;
  logic              start_i, abort_i;
  logic [1:0]        mode_i;
  logic [2:0]        lane_i;
  logic [NBITS-1:0]  amp_i;
  logic              busy_o, done_o, err_o;
  logic [7:0]        rd_addr_i;
  logic [BEAT_W-1:0] rd_data_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [BEAT_W-1:0] cur  [DEPTH];
  logic [BEAT_W-1:0] ref2 [DEPTH];
  logic signed [15:0] acc [DEPTH][NSAMP];

  lpf_impulse_sequencer #(.FLUSH_CYCLES(64), .CAPTURE_DEPTH(256)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .adc_tdata (adc_tdata),
    .lpf_in_o  (lpf_in_o),
    .lpf_out_i (lpf_out_i),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .mode_i    (mode_i),
    .lane_i    (lane_i),
    .amp_i     (amp_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

  always #5 aclk = ~aclk;

  // LPF stand-in: y[n] = (x[n] + 2x[n-1] + x[n-2]) / 4, one register of latency.
  logic signed [11:0] x1 [NSAMP];
  logic signed [11:0] x2 [NSAMP];
  logic signed [13:0] lsum [NSAMP];

  always_comb begin
    for (int j = 0; j < NSAMP; j++)
      lsum[j] = 14'($signed(lpf_in_o[12*j +: 12])) + 14'(x1[j]) + 14'(x1[j]) + 14'(x2[j]);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lpf_out_i <= '0;
      for (int j = 0; j < NSAMP; j++) begin
        x1[j] <= '0;
        x2[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NSAMP; j++) begin
        x1[j] <= $signed(lpf_in_o[12*j +: 12]);
        x2[j] <= x1[j];
        lpf_out_i[12*j +: 12] <= 12'(lsum[j] >>> 2);
      end
    end
  end

  function automatic logic [BEAT_W-1:0] ramp(input int c);
    logic [BEAT_W-1:0] b;
    for (int j = 0; j < NSAMP; j++) b[12*j +: 12] = 12'(c * 8 + j);
    return b;
  endfunction

  function automatic logic [BEAT_W-1:0] imp(input logic [7:0] mask, input int amp);
    logic [BEAT_W-1:0] b;
    b = '0;
    for (int j = 0; j < NSAMP; j++) if (mask[j]) b[12*j +: 12] = 12'(amp);
    return b;
  endfunction

  // Expected capture: beat k is the LPF output k cycles after the impulse beat.
  function automatic logic [BEAT_W-1:0] exp_cap(input int k, input logic [7:0] mask, input int amp);
    logic [BEAT_W-1:0] b;
    int v;
    v = (k == 1 || k == 3) ? amp / 4 : (k == 2) ? amp / 2 : 0;
    b = '0;
    for (int j = 0; j < NSAMP; j++) if (mask[j]) b[12*j +: 12] = 12'(v);
    return b;
  endfunction

  task automatic check(input string tag, input logic [BEAT_W-1:0] got, input logic [BEAT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic read_cap();
    for (int k = 0; k < DEPTH; k++) begin
      rd_addr_i = 8'(k);
      tick();
      cur[k] = rd_data_o;
    end
  endtask

  task automatic do_run(input logic [1:0] mode, input logic [2:0] lane, input int amp,
                        input logic [7:0] mask, input bit stray, input bit finish);
    int nz;
    int n;
    mode_i  = mode;
    lane_i  = lane;
    amp_i   = 12'(amp);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy_start", busy_o, 1);
    check("done_clr", done_o, 0);
    nz = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (lpf_in_o != '0) nz++;
      if (stray && i == 10) start_i = 1'b1;
      if (stray && i == 11) start_i = 1'b0;
    end
    check("flush_zero", nz, 0);
    tick();
    check("inject", lpf_in_o, imp(mask, amp));
    if (finish) begin
      n = 0;
      while (!done_o && n < 400) begin
        tick();
        n++;
      end
      check("done_lat", n, 256);
      check("busy_done", busy_o, 0);
      read_cap();
      for (int k = 0; k < DEPTH; k++) check($sformatf("cap%0d", k), cur[k], exp_cap(k, mask, amp));
    end
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      cyc++;
      adc_tdata = ramp(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [BEAT_W-1:0] nb;
    logic [11:0] t;
    logic signed [15:0] d;
    aresetn   = 1'b0;
    adc_tdata = '0;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    mode_i    = '0;
    lane_i    = '0;
    amp_i     = '0;
    rd_addr_i = '0;
    repeat (3) tick();
    check("rst_lpf_in", lpf_in_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rd", rd_data_o, 0);
    aresetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      tick();
      check("pass", lpf_in_o, ramp(cyc - 1));
      check("pass_busy", busy_o, 0);
    end

    do_run(2'd0, 3'd3, 1000, 8'h08, 1'b0, 1'b1);
    ref2 = cur;

    do_run(2'd0, 3'd3, -1000, 8'h08, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      for (int j = 0; j < NSAMP; j++) begin
        t = ref2[k][12*j +: 12];
        nb[12*j +: 12] = 12'd0 - t;
      end
      check($sformatf("neg%0d", k), cur[k], nb);
    end

    do_run(2'd1, 3'd6, 1000, 8'hC0, 1'b0, 1'b1);
    mode_i = 2'd1; lane_i = 3'd7; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("err_pair7", err_o, 1);
    check("err_busy", busy_o, 0);
    check("err_done", done_o, 1);
    tick();
    check("err_pulse", err_o, 0);
    mode_i = 2'd3; lane_i = 3'd0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("err_mode3", err_o, 1);
    check("err3_done", done_o, 1);

    for (int k = 0; k < DEPTH; k++)
      for (int j = 0; j < NSAMP; j++) acc[k][j] = '0;
    for (int l = 0; l < NSAMP; l++) begin
      do_run(2'd0, 3'(l), 1000, 8'(1 << l), 1'b0, 1'b1);
      for (int k = 0; k < DEPTH; k++)
        for (int j = 0; j < NSAMP; j++) acc[k][j] = acc[k][j] + 16'($signed(cur[k][12*j +: 12]));
    end
    do_run(2'd2, 3'd0, 1000, 8'hFF, 1'b0, 1'b1);
    bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int j = 0; j < NSAMP; j++) begin
        d = 16'($signed(cur[k][12*j +: 12])) - acc[k][j];
        if (d > 1 || d < -1) bad++;
      end
    end
    check("sum_all", bad, 0);

    do_run(2'd0, 3'd0, 400, 8'h01, 1'b1, 1'b0);
    repeat (100) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    tick();
    check("abort_pass", lpf_in_o, ramp(cyc - 1));
    rd_addr_i = 8'd2;
    tick();
    check("partial", rd_data_o, exp_cap(2, 8'h01, 400));

    mode_i = 2'd0; lane_i = 3'd1; amp_i = 12'd500; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    check("mid_busy", busy_o, 1);
    aresetn = 1'b0;
    #1;
    check("mrst_lpf_in", lpf_in_o, 0);
    check("mrst_busy", busy_o, 0);
    check("mrst_done", done_o, 0);
    check("mrst_err", err_o, 0);
    check("mrst_rd", rd_data_o, 0);
    tick();
    aresetn = 1'b1;
    tick();
    check("mrst_pass", lpf_in_o, ramp(cyc - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
